// File: rtl/uart_sector_link.sv
// UART sector-transfer engine: header, N sectors of data plus XOR checksum,
// RX byte timeout and direct access to a 32-bit word buffer.
module uart_sector_link #(
  parameter int DIV          = 16,
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 9,
  parameter int LSA_BYTES    = 2,
  parameter int TIMEOUT_CYC  = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_sel,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       status,
  output logic              irq,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              rx_in,
  output logic              tx_out
);
  // state | meaning
  // IDLE  | waiting for start
  // HDR   | sending FF, dir, LSA, N
  // RXD   | receiving sector data into the buffer
  // RXSUM | receiving and checking the sector checksum
  // TXD   | sending sector data from the buffer
  // TXSUM | sending the computed sector checksum
  // FIN   | one-cycle completion, done follows
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_HDR = 4'd1, S_RXD = 4'd2, S_RXSUM = 4'd3,
    S_TXD = 4'd4, S_TXSUM = 4'd5, S_FIN = 4'd6
  } state_t;

  localparam int DW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0] HDR_LAST = 16'(LSA_BYTES + 2);
  localparam logic [15:0] DAT_LAST = 16'(SECTOR_BYTES - 1);

  logic [2:0]    rx_sync_q;
  logic          rx_act_q;
  logic [DW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_s, rx_fall, rx_tick, rx_valid;

  assign rx_s     = rx_sync_q[1];
  assign rx_fall  = rx_sync_q[2] & ~rx_sync_q[1];
  assign rx_tick  = rx_act_q && (rx_cnt_q == '0);
  assign rx_valid = rx_tick && (rx_bit_q == 4'd9) && rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= '1;
      rx_act_q  <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[1:0], rx_in};
      if (!rx_act_q) begin
        if (rx_fall) begin
          rx_act_q <= 1'b1;
          rx_cnt_q <= DW'(DIV / 2 - 1);
          rx_bit_q <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - DW'(1);
      end else begin
        rx_cnt_q <= DW'(DIV - 1);
        // a start bit that is high again at mid-bit was a glitch
        if ((rx_bit_q == 4'd0 && rx_s) || rx_bit_q == 4'd9) begin
          rx_act_q <= 1'b0;
        end else begin
          if (rx_bit_q != 4'd0) rx_sh_q <= {rx_s, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end
      end
    end
  end

  state_t            state_q;
  logic [31:0]       lsa_q;
  logic [7:0]        n_q, sec_q, csum_q;
  logic              ie_q, dir_q, done_q;
  logic [1:0]        err_q;
  logic [15:0]       idx_q;
  logic [ADDR_W+1:0] b_q;
  logic [TW-1:0]     tmo_q;
  logic              tx_act_q;
  logic [DW-1:0]     tx_cnt_q;
  logic [3:0]        tx_bit_q;
  logic [9:0]        tx_sh_q;
  logic [3:0]        mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic              ctrl_wr, busy, abort_req, start_req, tx_end, tx_load;
  logic [7:0]        n_d, hdr_byte, tx_byte_d, mem_byte;
  logic [15:0]       hdr_idx;
  logic [ADDR_W+1:0] b_inc;

  assign ctrl_wr   = reg_sel && we[0];
  assign busy      = (state_q != S_IDLE);
  assign abort_req = ctrl_wr && wdata[6] && busy;
  assign start_req = ctrl_wr && wdata[5] && !wdata[6] && !busy;
  assign n_d       = we[1] ? wdata[15:8] : n_q;
  assign tx_end    = tx_act_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);
  assign mem_byte  = mem_rdata[{b_q[1:0], 3'b000} +: 8];
  assign b_inc     = b_q + (ADDR_W+2)'(1);

  always_comb begin
    hdr_idx  = tx_end ? idx_q + 16'd1 : idx_q;
    hdr_byte = 8'hFF;
    if (hdr_idx == 16'd1) hdr_byte = {7'd0, dir_q};
    for (int k = 0; k < LSA_BYTES; k++)
      if (hdr_idx == 16'(k + 2)) hdr_byte = lsa_q[8*k +: 8];
    if (hdr_idx == HDR_LAST) hdr_byte = sec_q;
  end

  // next frame is chosen in the last stop-bit cycle so frames run back-to-back
  always_comb begin
    tx_load   = 1'b0;
    tx_byte_d = hdr_byte;
    case (state_q)
      S_HDR:
        if (!tx_act_q || (tx_end && idx_q != HDR_LAST)) tx_load = 1'b1;
        else if (tx_end && dir_q) begin
          tx_load   = 1'b1;
          tx_byte_d = mem_byte;
        end
      S_TXD:
        if (tx_end) begin
          tx_load   = 1'b1;
          tx_byte_d = (idx_q == DAT_LAST) ? csum_q : mem_byte;
        end
      S_TXSUM:
        if (tx_end && sec_q != 8'd1) begin
          tx_load   = 1'b1;
          tx_byte_d = mem_byte;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lsa_q       <= '0;
      n_q         <= '0;
      sec_q       <= '0;
      csum_q      <= '0;
      ie_q        <= 1'b0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      idx_q       <= '0;
      b_q         <= '0;
      tmo_q       <= '0;
      tx_act_q    <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '1;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= '0;
      if (tx_act_q) begin
        if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - DW'(1);
        else if (tx_bit_q == 4'd9) begin
          tx_act_q <= 1'b0;
          tx_sh_q  <= '1;
        end else begin
          tx_cnt_q <= DW'(DIV - 1);
          tx_bit_q <= tx_bit_q + 4'd1;
          tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        end
      end
      if (tx_load) begin
        tx_act_q <= 1'b1;
        tx_cnt_q <= DW'(DIV - 1);
        tx_bit_q <= '0;
        tx_sh_q  <= {1'b1, tx_byte_d, 1'b0};
      end
      if (ctrl_wr) begin
        done_q <= 1'b0;
        err_q  <= '0;
        ie_q   <= wdata[7];
        n_q    <= n_d;
      end
      if (!busy && !reg_sel)
        for (int k = 0; k < 4; k++)
          if (we[k]) lsa_q[8*k +: 8] <= wdata[8*k +: 8];

      if (abort_req) begin
        state_q  <= S_IDLE;
        tx_act_q <= 1'b0;
        tx_sh_q  <= '1;
        err_q    <= 2'b11;
        done_q   <= 1'b1;
        mem_we_q <= '0;
      end else begin
        case (state_q)
          S_IDLE:
            if (start_req) begin
              if (n_d == 8'd0) begin
                err_q  <= 2'b11;
                done_q <= 1'b1;
              end else begin
                state_q    <= S_HDR;
                dir_q      <= wdata[4];
                sec_q      <= n_d;
                idx_q      <= '0;
                b_q        <= '0;
                mem_addr_q <= '0;
                csum_q     <= '0;
              end
            end
          S_HDR:
            if (tx_end) begin
              if (idx_q == HDR_LAST) begin
                idx_q <= '0;
                if (dir_q) begin
                  state_q    <= S_TXD;
                  csum_q     <= csum_q ^ mem_byte;
                  b_q        <= b_inc;
                  mem_addr_q <= b_inc[ADDR_W+1:2];
                end else begin
                  state_q <= S_RXD;
                  tmo_q   <= TW'(TIMEOUT_CYC);
                end
              end else idx_q <= idx_q + 16'd1;
            end
          S_TXD:
            if (tx_end) begin
              if (idx_q == DAT_LAST) begin
                state_q <= S_TXSUM;
                idx_q   <= 16'(SECTOR_BYTES);
              end else begin
                idx_q      <= idx_q + 16'd1;
                csum_q     <= csum_q ^ mem_byte;
                b_q        <= b_inc;
                mem_addr_q <= b_inc[ADDR_W+1:2];
              end
            end
          S_TXSUM:
            if (tx_end) begin
              sec_q <= sec_q - 8'd1;
              idx_q <= '0;
              if (sec_q == 8'd1) state_q <= S_FIN;
              else begin
                state_q    <= S_TXD;
                csum_q     <= mem_byte;
                b_q        <= b_inc;
                mem_addr_q <= b_inc[ADDR_W+1:2];
              end
            end
          S_RXD, S_RXSUM:
            if (rx_valid) begin
              tmo_q <= TW'(TIMEOUT_CYC);
              if (state_q == S_RXD) begin
                mem_we_q    <= 4'b0001 << b_q[1:0];
                mem_addr_q  <= b_q[ADDR_W+1:2];
                mem_wdata_q <= {4{rx_sh_q}};
                csum_q      <= csum_q ^ rx_sh_q;
                b_q         <= b_inc;
                if (idx_q == DAT_LAST) begin
                  state_q <= S_RXSUM;
                  idx_q   <= 16'(SECTOR_BYTES);
                end else idx_q <= idx_q + 16'd1;
              end else if (rx_sh_q != csum_q) begin
                err_q   <= 2'b01;
                state_q <= S_FIN;
              end else begin
                sec_q   <= sec_q - 8'd1;
                csum_q  <= '0;
                idx_q   <= '0;
                state_q <= (sec_q == 8'd1) ? S_FIN : S_RXD;
              end
            end else if (tmo_q == '0) begin
              err_q   <= 2'b10;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else tmo_q <= tmo_q - TW'(1);
          S_FIN: begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign status    = {busy, done_q, err_q, sec_q, state_q, idx_q};
  assign irq       = ie_q & (done_q | (|err_q));
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign tx_out    = tx_sh_q[0];
endmodule

// File: tb/tb_uart_sector_link.sv
// Directed bench for uart_sector_link: write/read transfers, checksum error,
// RX timeout, abort and start corner cases.
module tb_uart_sector_link;
  localparam int DIV = 4;
  localparam int SB  = 8;
  localparam int AW  = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reg_sel = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] wdata = '0;
  logic [31:0] status;
  logic        irq;
  logic [3:0]  mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rx_in = 1'b1;
  logic        tx_out;

  uart_sector_link #(.DIV(DIV), .SECTOR_BYTES(SB), .ADDR_W(AW), .LSA_BYTES(2),
                     .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .reg_sel(reg_sel), .we(we), .wdata(wdata),
    .status(status), .irq(irq), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rx_in(rx_in), .tx_out(tx_out));

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else for (int k = 0; k < 4; k++)
      if (mem_we[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rdata <= mem[mem_addr];
  end

  // host-side receiver of the DUT's serial output
  logic [7:0] txq[$];
  logic [7:0] mon_b;
  int tx_edges = 0;
  always @(negedge tx_out) tx_edges++;
  initial begin
    forever begin
      @(negedge tx_out);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        mon_b[i] = tx_out;
      end
      repeat (DIV) @(negedge clk);
      txq.push_back(mon_b);
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [3:0] w, input logic [31:0] d);
    cyc(1);
    reg_sel = sel; we = w; wdata = d;
    cyc(1);
    we = '0;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = AW'(a); pl_data = d;
    cyc(1);
    pl_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_in = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      cyc(DIV);
    end
    rx_in = 1'b1;
    cyc(DIV);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int bound);
    int n;
    logic seen;
    seen = 1'b0;
    for (n = 0; n < bound && !seen; n++) begin
      cyc(1);
      if (status[19:16] == st) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int bound, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (n < bound && !seen) begin
      cyc(1);
      n++;
      if (status[30]) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  logic [7:0] exp_w [14];
  int base, cnt;

  initial begin
    exp_w = '{8'hFF, 8'h01, 8'h34, 8'h12, 8'h01, 8'h00, 8'h01, 8'h02,
              8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
    #1 rst_n = 1'b0;
    cyc(3);
    check("rst_tx_out", {31'd0, tx_out}, 32'd1);
    check("rst_status", status, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    cyc(2);
    base = tx_edges;
    wr(1'b1, 4'b0001, 32'h0);
    cyc(60);
    check("nostart_edges", tx_edges - base, 32'd0);
    check("nostart_status", status, 32'h0);

    // write transfer, N=1
    preload(0, 32'h03020100);
    preload(1, 32'h07060504);
    wr(1'b0, 4'hF, 32'h0000_1234);
    base = txq.size();
    wr(1'b1, 4'b0011, 32'h0000_0130);
    wait_done("wr_done_seen", 1000, cnt);
    check("wr_done_time_ok", {31'd0, (cnt >= 560 && cnt <= 564)}, 32'd1);
    check("wr_byte_count", txq.size() - base, 32'd14);
    for (int i = 0; i < 14; i++)
      if (base + i < txq.size()) check($sformatf("wr_byte%0d", i), {24'd0, txq[base+i]}, {24'd0, exp_w[i]});
    check("wr_status", status, 32'h4000_0000);
    check("wr_irq_ie0", {31'd0, irq}, 32'd0);

    // read transfer, N=2, ie=1
    base = txq.size();
    wr(1'b1, 4'b0011, 32'h0000_02A0);
    wait_state("rd_enter_rxd", 4'd2, 400);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    send_byte(8'h00);
    for (int i = 8; i < 16; i++) send_byte(8'hA0 + 8'(i));
    send_byte(8'h00);
    wait_done("rd_done_seen", 200, cnt);
    check("rd_hdr_dir", (txq.size() > base + 4) ? {24'd0, txq[base+1]} : 32'hFFFF, 32'h00);
    check("rd_hdr_n", (txq.size() > base + 4) ? {24'd0, txq[base+4]} : 32'hFFFF, 32'h02);
    check("rd_word0", mem[0], 32'hA3A2A1A0);
    check("rd_word1", mem[1], 32'hA7A6A5A4);
    check("rd_word2", mem[2], 32'hABAAA9A8);
    check("rd_word3", mem[3], 32'hAFAEADAC);
    check("rd_status", status, 32'h4000_0000);
    check("rd_irq", {31'd0, irq}, 32'd1);
    wr(1'b1, 4'b0001, 32'h0);
    check("clr_irq", {31'd0, irq}, 32'd0);
    check("clr_done", {31'd0, status[30]}, 32'd0);

    // bad checksum on sector 0
    wr(1'b1, 4'b0011, 32'h0000_0220);
    wait_state("bad_enter_rxd", 4'd2, 400);
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    send_byte(8'hFF);
    cyc(4);
    check("bad_flags", {28'd0, status[31:28]}, 32'h5);
    for (int i = 0; i < 8; i++) send_byte(8'h55);
    check("bad_word0", mem[0], 32'h13121110);
    check("bad_word1", mem[1], 32'h17161514);
    check("bad_word2_kept", mem[2], 32'hABAAA9A8);
    check("bad_word3_kept", mem[3], 32'hAFAEADAC);

    // abort during the 2nd data byte (0x11: d0=1, d1=0)
    wr(1'b1, 4'b0011, 32'h0000_0130);
    cyc(249);
    check("abort_pre_tx", {31'd0, tx_out}, 32'd0);
    wr(1'b1, 4'b0001, 32'h0000_0040);
    check("abort_tx_high", {31'd0, tx_out}, 32'd1);
    check("abort_flags", {28'd0, status[31:28]}, 32'h7);
    check("abort_state", {28'd0, status[19:16]}, 32'h0);
    cyc(60);

    // start with N=0
    base = tx_edges;
    wr(1'b1, 4'b0011, 32'h0000_00A0);
    check("n0_flags", {28'd0, status[31:28]}, 32'h7);
    check("n0_irq", {31'd0, irq}, 32'd1);
    cyc(50);
    check("n0_edges", tx_edges - base, 32'd0);

    // start while busy is ignored, LSA write while busy is ignored
    base = txq.size();
    wr(1'b1, 4'b0011, 32'h0000_0130);
    cyc(30);
    wr(1'b1, 4'b0011, 32'h0000_0320);
    wr(1'b0, 4'hF, 32'h0000_DEAD);
    check("busy_sec_state", {20'd0, status[27:16]}, 32'h011);
    wait_done("busy_done_seen", 1000, cnt);
    check("busy_byte_count", txq.size() - base, 32'd14);
    for (int i = 0; i < 5; i++)
      if (base + i < txq.size()) check($sformatf("busy_hdr%0d", i), {24'd0, txq[base+i]}, {24'd0, exp_w[i]});
    check("busy_csum", (txq.size() >= base + 14) ? {24'd0, txq[base+13]} : 32'hFFFF, 32'h00);

    // RX timeout after 3 data bytes
    wr(1'b1, 4'b0011, 32'h0000_0120);
    wait_state("tmo_enter_rxd", 4'd2, 400);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    cnt = 0;
    while (cnt < 300 && status[29:28] == 2'b00) begin
      cyc(1);
      cnt++;
    end
    check("tmo_err", {30'd0, status[29:28]}, 32'h2);
    check("tmo_time_ok", {31'd0, (cnt >= 90 && cnt <= 115)}, 32'd1);
    check("tmo_busy", {31'd0, status[31]}, 32'd0);
    check("tmo_word0", mem[0], 32'h13030201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
